// File: rtl/stateful_atom_array_pkg.sv
// Shared definitions for the stateful atom array: atom operation encoding
// and the default geometry of the entry array.
package stateful_atom_array_pkg;

  localparam int DEFAULT_COUNT_WIDTH = 3;
  localparam int DEFAULT_DEPTH       = 4;

  typedef enum logic [1:0] {
    MODE_WRITE   = 2'b00,
    MODE_ADD     = 2'b01,
    MODE_SAT_ADD = 2'b10,
    MODE_READ    = 2'b11
  } atom_mode_e;

endpackage

// File: rtl/stateful_atom_array_alu.sv
// Combinational atom ALU: derives the new entry value from the old value,
// the selected operand and the requested operation.
module atom_alu
  import stateful_atom_array_pkg::*;
#(
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic [COUNT_WIDTH-1:0] old_i,
  input  logic [COUNT_WIDTH-1:0] operand_i,
  input  atom_mode_e             mode_i,
  output logic [COUNT_WIDTH-1:0] new_o
);

  logic [COUNT_WIDTH:0] sum;

  // Sum is one bit wider so the carry tells saturating add when to clamp
  always_comb begin
    sum   = {1'b0, old_i} + {1'b0, operand_i};
    new_o = old_i;
    case (mode_i)
      MODE_WRITE:   new_o = operand_i;
      MODE_ADD:     new_o = sum[COUNT_WIDTH-1:0];
      MODE_SAT_ADD: new_o = sum[COUNT_WIDTH] ? {COUNT_WIDTH{1'b1}} : sum[COUNT_WIDTH-1:0];
      MODE_READ:    new_o = old_i;
      default:      new_o = old_i;
    endcase
  end

endmodule

// File: rtl/stateful_atom_array.sv
// Stateful atom array: a two-stage pipeline that applies a read-modify-write
// atom operation to one entry of a small register array per request.
module stateful_atom_array
  import stateful_atom_array_pkg::*;
#(
  parameter  int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
  parameter  int DEPTH       = DEFAULT_DEPTH,
  localparam int IDX_WIDTH   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i__valid,
  input  logic [IDX_WIDTH-1:0]   i__index,
  input  logic [COUNT_WIDTH-1:0] i__constant,
  input  logic [COUNT_WIDTH-1:0] i__pkt_1,
  input  logic                   i__sel,
  input  logic [1:0]             i__mode,
  output logic                   o__valid,
  output logic [IDX_WIDTH-1:0]   o__index,
  output logic [COUNT_WIDTH-1:0] o__read,
  output logic [COUNT_WIDTH-1:0] o__write
);

  localparam logic [IDX_WIDTH:0] DEPTH_LIMIT = (IDX_WIDTH+1)'(DEPTH);

  logic                   a_valid_q,   a_valid_d;
  logic [IDX_WIDTH-1:0]   a_index_q,   a_index_d;
  logic [COUNT_WIDTH-1:0] a_operand_q, a_operand_d;
  atom_mode_e             a_mode_q,    a_mode_d;

  logic [COUNT_WIDTH-1:0] entry_q [DEPTH];

  logic                   b_valid_q;
  logic [IDX_WIDTH-1:0]   b_index_q;
  logic [COUNT_WIDTH-1:0] b_read_q;
  logic [COUNT_WIDTH-1:0] b_write_q;

  logic [COUNT_WIDTH-1:0] old_value;
  logic [COUNT_WIDTH-1:0] new_value;

  // Operand select, plus folding of out-of-range indices into a harmless read of entry 0
  always_comb begin
    a_valid_d   = i__valid;
    a_index_d   = i__index;
    a_operand_d = i__sel ? i__pkt_1 : i__constant;
    a_mode_d    = atom_mode_e'(i__mode);
    if ({1'b0, i__index} >= DEPTH_LIMIT) begin
      a_index_d = '0;
      a_mode_d  = MODE_READ;
    end
  end

  // Stage A register: a request seen during reset never enters the pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_valid_q   <= 1'b0;
      a_index_q   <= '0;
      a_operand_q <= '0;
      a_mode_q    <= MODE_WRITE;
    end else begin
      a_valid_q   <= a_valid_d;
      a_index_q   <= a_index_d;
      a_operand_q <= a_operand_d;
      a_mode_q    <= a_mode_d;
    end
  end

  // The entry is written at the same edge the next request enters stage B, so no bypass is needed
  assign old_value = entry_q[a_index_q];

  atom_alu #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_alu (
    .old_i     (old_value),
    .operand_i (a_operand_q),
    .mode_i    (a_mode_q),
    .new_o     (new_value)
  );

  // Stage B: commit the new entry value and register results; idle cycles hold the last result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      b_valid_q <= 1'b0;
      b_index_q <= '0;
      b_read_q  <= '0;
      b_write_q <= '0;
    end else begin
      b_valid_q <= a_valid_q;
      if (a_valid_q) begin
        entry_q[a_index_q] <= new_value;
        b_index_q          <= a_index_q;
        b_read_q           <= old_value;
        b_write_q          <= new_value;
      end
    end
  end

  assign o__valid = b_valid_q;
  assign o__index = b_index_q;
  assign o__read  = b_read_q;
  assign o__write = b_write_q;

endmodule

// File: tb/tb_stateful_atom_array.sv
// Testbench for stateful_atom_array: directed scenarios followed by random
// traffic, all compared against a request-level reference model.
module tb_stateful_atom_array;

  localparam int CW     = 3;
  localparam int DEPTH  = 4;
  localparam int IW     = 2;
  localparam int MAXV   = (1 << CW) - 1;

  localparam logic [1:0] M_WRITE   = 2'd0;
  localparam logic [1:0] M_ADD     = 2'd1;
  localparam logic [1:0] M_SAT_ADD = 2'd2;
  localparam logic [1:0] M_READ    = 2'd3;

  logic          clk;
  logic          rst_n;
  logic          i__valid;
  logic [IW-1:0] i__index;
  logic [CW-1:0] i__constant;
  logic [CW-1:0] i__pkt_1;
  logic          i__sel;
  logic [1:0]    i__mode;
  logic          o__valid;
  logic [IW-1:0] o__index;
  logic [CW-1:0] o__read;
  logic [CW-1:0] o__write;

  int checks = 0;
  int errors = 0;

  // Reference model state: entry contents, the one request awaiting commit, and expected outputs
  int mem [DEPTH];
  bit pendValid;
  int pendIdx, pendOp, pendMode;
  int expValid, expIdx, expRd, expWr;

  stateful_atom_array #(
    .COUNT_WIDTH (CW),
    .DEPTH       (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i__valid    (i__valid),
    .i__index    (i__index),
    .i__constant (i__constant),
    .i__pkt_1    (i__pkt_1),
    .i__sel      (i__sel),
    .i__mode     (i__mode),
    .o__valid    (o__valid),
    .o__index    (o__index),
    .o__read     (o__read),
    .o__write    (o__write)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("model_valid", {31'b0, o__valid}, expValid);
    check("model_index", {30'b0, o__index}, expIdx);
    check("model_read",  {29'b0, o__read},  expRd);
    check("model_write", {29'b0, o__write}, expWr);
  endtask

  // Advance the model by one clock edge: commit the pending request, then accept the new one
  task automatic modelEdge(input bit rstn, input bit vld, input int idx, input int op, input int mode);
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 0;
      pendValid = 1'b0;
      expValid  = 0;
      expIdx    = 0;
      expRd     = 0;
      expWr     = 0;
    end else begin
      if (pendValid) begin
        expRd = mem[pendIdx];
        case (pendMode)
          0:       expWr = pendOp;
          1:       expWr = (expRd + pendOp) % (MAXV + 1);
          2:       expWr = (expRd + pendOp > MAXV) ? MAXV : expRd + pendOp;
          default: expWr = expRd;
        endcase
        mem[pendIdx] = expWr;
        expIdx   = pendIdx;
        expValid = 1;
      end else begin
        expValid = 0;
      end
      pendValid = vld;
      pendIdx   = idx;
      pendOp    = op;
      pendMode  = mode;
    end
  endtask

  // Drive one cycle of inputs (from a negedge), update the model, check just after the rising edge
  task automatic applyStimulus(input bit rstn, input bit vld, input int idx, input int cst,
                               input int pkt, input bit sel, input int mode);
    rst_n       = rstn;
    i__valid    = vld;
    i__index    = IW'(idx);
    i__constant = CW'(cst);
    i__pkt_1    = CW'(pkt);
    i__sel      = sel;
    i__mode     = 2'(mode);
    modelEdge(rstn, vld, idx, sel ? pkt : cst, mode);
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  task automatic req(input int idx, input int cst, input int pkt, input bit sel, input int mode);
    applyStimulus(1'b1, 1'b1, idx, cst, pkt, sel, mode);
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 0, 0, 0, 1'b0, 0);
  endtask

  task automatic expectResult(input string tag, input int idx, input int rd, input int wr);
    check({tag, "_valid"}, {31'b0, o__valid}, 1);
    check({tag, "_index"}, {30'b0, o__index}, idx);
    check({tag, "_read"},  {29'b0, o__read},  rd);
    check({tag, "_write"}, {29'b0, o__write}, wr);
  endtask

  // Directed scenarios, then randomized traffic with occasional resets
  initial begin
    rst_n       = 1'b0;
    i__valid    = 1'b0;
    i__index    = '0;
    i__constant = '0;
    i__pkt_1    = '0;
    i__sel      = 1'b0;
    i__mode     = '0;
    @(negedge clk);

    applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 3, 7, 7, 1'b0, M_WRITE);
    check("reset_valid", {31'b0, o__valid}, 0);
    check("reset_write", {29'b0, o__write}, 0);

    // Write with constant operand
    req(2, 5, 1, 1'b0, M_WRITE);
    check("write_latency_valid", {31'b0, o__valid}, 0);
    idle();
    expectResult("write_idx2", 2, 0, 5);

    // Back-to-back adds with wrap
    req(1, 0, 3, 1'b1, M_ADD);
    req(1, 0, 3, 1'b1, M_ADD);
    expectResult("add1", 1, 0, 3);
    req(1, 0, 3, 1'b1, M_ADD);
    expectResult("add2", 1, 3, 6);
    idle();
    expectResult("add3_wrap", 1, 6, 1);

    // Saturating adds
    req(3, 0, 6, 1'b1, M_SAT_ADD);
    req(3, 0, 6, 1'b1, M_SAT_ADD);
    expectResult("sat1", 3, 0, 6);
    req(3, 0, 1, 1'b1, M_SAT_ADD);
    expectResult("sat2_clamp", 3, 6, 7);
    idle();
    expectResult("sat3_clamp", 3, 7, 7);

    // Interleaved writes and reads
    req(0, 4, 0, 1'b0, M_WRITE);
    req(1, 2, 0, 1'b0, M_WRITE);
    req(0, 0, 0, 1'b0, M_READ);
    req(1, 0, 0, 1'b0, M_READ);
    expectResult("read_idx0", 0, 4, 4);
    idle();
    expectResult("read_idx1", 1, 2, 2);

    // Reset flushes an in-flight add and ignores the request presented with it
    req(2, 0, 1, 1'b1, M_ADD);
    applyStimulus(1'b0, 1'b1, 2, 0, 1, 1'b1, M_ADD);
    check("flush_valid_a", {31'b0, o__valid}, 0);
    idle();
    check("flush_valid_b", {31'b0, o__valid}, 0);
    req(2, 0, 0, 1'b0, M_READ);
    idle();
    expectResult("post_reset_read", 2, 0, 0);

    // Idle gap: no results, outputs hold
    req(3, 2, 0, 1'b0, M_WRITE);
    idle();
    expectResult("gap_write", 3, 0, 2);
    for (int k = 0; k < 3; k++) begin
      idle();
      check("gap_valid", {31'b0, o__valid}, 0);
      check("gap_hold_index", {30'b0, o__index}, 3);
      check("gap_hold_write", {29'b0, o__write}, 2);
    end
    req(3, 0, 0, 1'b0, M_READ);
    idle();
    expectResult("gap_read", 3, 2, 2);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0,
                    int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, MAXV)),
                    int'($urandom_range(0, MAXV)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)));
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
